// File: rtl/gx4000_asic_pkg.sv
// Shared definitions for the Plus ASIC unlock gate: key table, FSM states, RMR2 tag.
package gx4000_asic_pkg;

    localparam int unsigned KEY_MAX_LEN     = 14;
    localparam logic [7:0]  UNLOCK_BYTE_DEF = 8'hEE;
    localparam logic [2:0]  RMR2_TAG        = 3'b101;

    localparam logic [7:0] KEY_TABLE [KEY_MAX_LEN] = '{
        8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
        8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD
    };

    typedef enum logic [1:0] {
        SYNC_NZ,
        SYNC_Z,
        KEY,
        FINAL
    } unlock_state_t;

    function automatic logic [7:0] key_at(input int unsigned idx);
        return (idx < KEY_MAX_LEN) ? KEY_TABLE[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/gx4000_wr_edge.sv
// CPU write-strobe edge detector with CRTC / gate-array port decode on the high address byte.
module gx4000_wr_edge #(
    parameter logic [7:0] PORT_HI    = 8'hBC,
    parameter logic [7:0] GA_PORT_HI = 8'h7F
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cpu_wr,
    input  logic [7:0] addr_hi,
    output logic       crtc_hit,
    output logic       ga_hit
);

    logic cpu_wr_q;
    logic wr_evt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_wr_q <= 1'b0;
        end else begin
            cpu_wr_q <= cpu_wr;
        end
    end

    // A long strobe yields a single event on its rising edge.
    assign wr_evt   = cpu_wr & ~cpu_wr_q;
    assign crtc_hit = wr_evt & (addr_hi == PORT_HI);
    assign ga_hit   = wr_evt & (addr_hi == GA_PORT_HI);

endmodule

// File: rtl/gx4000_asic_unlock.sv
// Plus ASIC unlock gate: sync+key detection on the CRTC port, RMR2 decode on the gate-array port.
// Optional GX4000_UNLOCK_DBG_EN enables the saturating attempt/mismatch debug counters.
module gx4000_asic_unlock
    import gx4000_asic_pkg::*;
#(
    parameter int unsigned SEQ_LEN     = 14,
    parameter logic [7:0]  PORT_HI     = 8'hBC,
    parameter logic [7:0]  GA_PORT_HI  = 8'h7F,
    parameter logic [7:0]  UNLOCK_BYTE = UNLOCK_BYTE_DEF
) (
    input  logic                             clk_sys,
    input  logic                             reset,
    input  logic                             plus_mode,
    input  logic [15:0]                      cpu_addr,
    input  logic [7:0]                       cpu_data_in,
    input  logic                             cpu_wr,
    output logic                             asic_unlocked,
    output logic                             asic_page_en,
    output logic [4:0]                       rmr2_q,
    output logic [$clog2(SEQ_LEN+1)-1:0]     seq_pos,
    output logic                             unlock_pulse,
    output logic                             lock_pulse,
    output logic [15:0]                      dbg_attempts,
    output logic [15:0]                      dbg_mismatch
);

    localparam int unsigned      PosW    = $clog2(SEQ_LEN + 1);
    localparam logic [PosW-1:0]  LastPos = PosW'(SEQ_LEN - 1);

    if (GA_PORT_HI == PORT_HI) begin : g_bad_ports
        $error("GA_PORT_HI must differ from PORT_HI");
    end
    if (SEQ_LEN < 1 || SEQ_LEN > KEY_MAX_LEN) begin : g_bad_len
        $error("SEQ_LEN out of range of the key table");
    end

    logic            crtc_hit;
    logic            ga_hit;
    logic            clr;
    logic [7:0]      d;

    unlock_state_t   state_q, state_d;
    logic [PosW-1:0] seq_q, seq_d;
    logic            unlocked_q, unlocked_d;
    logic            page_en_q, page_en_d;
    logic [4:0]      rmr2_d;
    logic            unlock_pulse_d, lock_pulse_d;
    logic            att_inc, mis_inc;

    gx4000_wr_edge #(
        .PORT_HI    (PORT_HI),
        .GA_PORT_HI (GA_PORT_HI)
    ) u_wr_edge (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .cpu_wr   (cpu_wr),
        .addr_hi  (cpu_addr[15:8]),
        .crtc_hit (crtc_hit),
        .ga_hit   (ga_hit)
    );

    assign clr = reset | ~plus_mode;
    assign d   = cpu_data_in;

    always_ff @(posedge clk_sys) begin
        if (clr) begin
            state_q      <= SYNC_NZ;
            seq_q        <= '0;
            unlocked_q   <= 1'b0;
            page_en_q    <= 1'b0;
            rmr2_q       <= '0;
            unlock_pulse <= 1'b0;
            lock_pulse   <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            unlocked_q   <= unlocked_d;
            page_en_q    <= page_en_d;
            rmr2_q       <= rmr2_d;
            unlock_pulse <= unlock_pulse_d;
            lock_pulse   <= lock_pulse_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        seq_d          = seq_q;
        unlocked_d     = unlocked_q;
        page_en_d      = page_en_q;
        rmr2_d         = rmr2_q;
        unlock_pulse_d = 1'b0;
        lock_pulse_d   = 1'b0;
        att_inc        = 1'b0;
        mis_inc        = 1'b0;

        if (crtc_hit) begin
            case (state_q)
                SYNC_NZ: begin
                    if (d != 8'h00) state_d = SYNC_Z;
                end
                SYNC_Z: begin
                    if (d == 8'h00) begin
                        state_d = KEY;
                        seq_d   = '0;
                        att_inc = 1'b1;
                    end
                end
                KEY: begin
                    if (d == key_at(int'(seq_q))) begin
                        seq_d = seq_q + PosW'(1);
                        if (seq_q == LastPos) state_d = FINAL;
                    end else begin
                        // Any mismatch leaves us resynced: a fresh zero restarts the key.
                        mis_inc = 1'b1;
                        seq_d   = '0;
                        state_d = SYNC_Z;
                    end
                end
                FINAL: begin
                    seq_d   = '0;
                    state_d = SYNC_NZ;
                    if (d == UNLOCK_BYTE) begin
                        unlocked_d     = 1'b1;
                        unlock_pulse_d = ~unlocked_q;
                    end else begin
                        unlocked_d   = 1'b0;
                        page_en_d    = 1'b0;
                        lock_pulse_d = unlocked_q;
                    end
                end
                default: state_d = SYNC_NZ;
            endcase
        end

        if (ga_hit && unlocked_q && d[7:5] == RMR2_TAG) begin
            rmr2_d    = d[4:0];
            page_en_d = (d[4:3] == 2'b11);
        end
    end

    assign asic_unlocked = unlocked_q;
    assign asic_page_en  = page_en_q;
    assign seq_pos       = seq_q;

`ifdef GX4000_UNLOCK_DBG_EN
    logic [15:0] att_q, mis_q;

    always_ff @(posedge clk_sys) begin
        if (clr) begin
            att_q <= '0;
            mis_q <= '0;
        end else begin
            if (att_inc && att_q != 16'hFFFF) att_q <= att_q + 16'd1;
            if (mis_inc && mis_q != 16'hFFFF) mis_q <= mis_q + 16'd1;
        end
    end

    assign dbg_attempts = att_q;
    assign dbg_mismatch = mis_q;
`else
    logic unused_dbg;
    assign unused_dbg   = att_inc ^ mis_inc;
    assign dbg_attempts = '0;
    assign dbg_mismatch = '0;
`endif

    logic unused_addr;
    assign unused_addr = ^cpu_addr[7:0];

endmodule

// File: tb/tb_gx4000_asic_unlock.sv
// Self-checking bench for gx4000_asic_unlock: write-vector table plus hand sequences for
// held strobes, mid-sequence reset and plus_mode drop.
module tb_gx4000_asic_unlock;

    typedef struct packed {
        logic [3:0]  seq;
        logic        unl;
        logic        pe;
        logic [4:0]  rmr2;
        logic        up;
        logic        lp;
        logic [15:0] att;
        logic [15:0] mis;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        exp_t        exp;
    } vec_t;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        plus_mode;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_wr;
    logic        asic_unlocked;
    logic        asic_page_en;
    logic [4:0]  rmr2_q;
    logic [3:0]  seq_pos;
    logic        unlock_pulse;
    logic        lock_pulse;
    logic [15:0] dbg_attempts;
    logic [15:0] dbg_mismatch;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[$];
    logic [7:0] keys [14];

    gx4000_asic_unlock u_dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .plus_mode     (plus_mode),
        .cpu_addr      (cpu_addr),
        .cpu_data_in   (cpu_data_in),
        .cpu_wr        (cpu_wr),
        .asic_unlocked (asic_unlocked),
        .asic_page_en  (asic_page_en),
        .rmr2_q        (rmr2_q),
        .seq_pos       (seq_pos),
        .unlock_pulse  (unlock_pulse),
        .lock_pulse    (lock_pulse),
        .dbg_attempts  (dbg_attempts),
        .dbg_mismatch  (dbg_mismatch)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Debug counters read as zero unless the feature is compiled in.
    function automatic logic [15:0] dx(input int v);
`ifdef GX4000_UNLOCK_DBG_EN
        return 16'(v);
`else
        return (v == 0) ? 16'h0 : 16'h0;
`endif
    endfunction

    function automatic exp_t mk(input int s, input bit u, input bit p, input int r,
                                input bit up, input bit lp, input int a, input int m);
        exp_t e;
        e.seq  = 4'(s);
        e.unl  = u;
        e.pe   = p;
        e.rmr2 = 5'(r);
        e.up   = up;
        e.lp   = lp;
        e.att  = dx(a);
        e.mis  = dx(m);
        return e;
    endfunction

    function automatic void add(input logic [15:0] a, input logic [7:0] d, input exp_t e);
        vec_t v;
        v.addr = a;
        v.data = d;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    // Full sync+key+terminator sequence; a is the attempt count after the sync zero.
    function automatic void add_seq(input logic [7:0] fin, input int a, input int m,
                                    input bit u, input bit p, input int r, input exp_t last);
        add(16'hBC00, 8'hFF, mk(0, u, p, r, 0, 0, a - 1, m));
        add(16'hBC00, 8'h00, mk(0, u, p, r, 0, 0, a, m));
        for (int i = 0; i < 14; i++) add(16'hBC00 | 16'(i), keys[i], mk(i + 1, u, p, r, 0, 0, a, m));
        add(16'hBC00, fin, last);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic check_out(input exp_t e, input string nm);
        chk({nm, ".seq_pos"},       32'(seq_pos),       32'(e.seq));
        chk({nm, ".asic_unlocked"}, 32'(asic_unlocked), 32'(e.unl));
        chk({nm, ".asic_page_en"},  32'(asic_page_en),  32'(e.pe));
        chk({nm, ".rmr2_q"},        32'(rmr2_q),        32'(e.rmr2));
        chk({nm, ".unlock_pulse"},  32'(unlock_pulse),  32'(e.up));
        chk({nm, ".lock_pulse"},    32'(lock_pulse),    32'(e.lp));
        chk({nm, ".dbg_attempts"},  32'(dbg_attempts),  32'(e.att));
        chk({nm, ".dbg_mismatch"},  32'(dbg_mismatch),  32'(e.mis));
    endtask

    // Called at a negedge; holds the strobe for 'hold' clocks, then one idle clock.
    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input exp_t e,
                            input int hold, input string nm);
        exp_t idle;
        cpu_addr    = a;
        cpu_data_in = d;
        cpu_wr      = 1'b1;
        for (int k = 0; k < hold; k++) begin
            sb.push_back(e);
            @(negedge clk_sys);
            check_out(sb.pop_front(), $sformatf("%s.c%0d", nm, k));
            e.up = 1'b0;
            e.lp = 1'b0;
        end
        cpu_wr  = 1'b0;
        idle    = e;
        sb.push_back(idle);
        @(negedge clk_sys);
        check_out(sb.pop_front(), {nm, ".idle"});
    endtask

    initial begin
        keys = '{8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
                 8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD};

        // Unlock, with a foreign-port write and a locked RMR2 write in the middle.
        add(16'hBC00, 8'hFF, mk(0, 0, 0, 0, 0, 0, 0, 0));
        add(16'hBC00, 8'h00, mk(0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 14; i++) begin
            add(16'hBC00 | 16'(i), keys[i], mk(i + 1, 0, 0, 0, 0, 0, 1, 0));
            if (i == 6) begin
                add(16'h1200, keys[7], mk(7, 0, 0, 0, 0, 0, 1, 0));
                add(16'h7F00, 8'hB8,   mk(7, 0, 0, 0, 0, 0, 1, 0));
            end
        end
        add(16'hBC00, 8'hEE, mk(0, 1, 0, 0, 1, 0, 1, 0));
        // RMR2 decode while unlocked.
        add(16'h7F00, 8'hB8, mk(0, 1, 1, 5'h18, 0, 0, 1, 0));
        add(16'h7F00, 8'h98, mk(0, 1, 1, 5'h18, 0, 0, 1, 0));
        add(16'h7F00, 8'hA5, mk(0, 1, 0, 5'h05, 0, 0, 1, 0));
        add(16'h7F00, 8'hB8, mk(0, 1, 1, 5'h18, 0, 0, 1, 0));
        // Relock, then relock again while already locked (no pulse).
        add_seq(8'h00, 2, 0, 1, 1, 5'h18, mk(0, 0, 0, 5'h18, 0, 1, 2, 0));
        add(16'h7F00, 8'hA3, mk(0, 0, 0, 5'h18, 0, 0, 2, 0));
        add_seq(8'h42, 3, 0, 0, 0, 5'h18, mk(0, 0, 0, 5'h18, 0, 0, 3, 0));
        // Mismatch at the fifth key byte, then a clean unlock.
        add(16'hBC00, 8'hFF, mk(0, 0, 0, 5'h18, 0, 0, 3, 0));
        add(16'hBC00, 8'h00, mk(0, 0, 0, 5'h18, 0, 0, 4, 0));
        for (int i = 0; i < 4; i++) add(16'hBC00, keys[i], mk(i + 1, 0, 0, 5'h18, 0, 0, 4, 0));
        add(16'hBC00, 8'h00, mk(0, 0, 0, 5'h18, 0, 0, 4, 1));
        add_seq(8'hEE, 5, 1, 0, 0, 5'h18, mk(0, 1, 0, 5'h18, 1, 0, 5, 1));

        reset       = 1'b1;
        plus_mode   = 1'b1;
        cpu_addr    = '0;
        cpu_data_in = '0;
        cpu_wr      = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_out(mk(0, 0, 0, 0, 0, 0, 0, 0), "reset");
        reset = 1'b0;
        @(negedge clk_sys);

        for (int i = 0; i < vecs.size(); i++)
            do_write(vecs[i].addr, vecs[i].data, vecs[i].exp, 1, $sformatf("vec%0d", i));

        // Held strobe counts once; then reset at seq_pos 7 while unlocked.
        do_write(16'h7F00, 8'hB8, mk(0, 1, 1, 5'h18, 0, 0, 5, 1), 1, "pe_on");
        do_write(16'hBC00, 8'hFF, mk(0, 1, 1, 5'h18, 0, 0, 5, 1), 1, "h_sync1");
        do_write(16'hBC00, 8'h00, mk(0, 1, 1, 5'h18, 0, 0, 6, 1), 1, "h_sync0");
        do_write(16'hBC00, keys[0], mk(1, 1, 1, 5'h18, 0, 0, 6, 1), 5, "held");
        for (int i = 1; i < 7; i++)
            do_write(16'hBC00, keys[i], mk(i + 1, 1, 1, 5'h18, 0, 0, 6, 1), 1,
                     $sformatf("pre_rst%0d", i));
        reset = 1'b1;
        @(negedge clk_sys);
        check_out(mk(0, 0, 0, 0, 0, 0, 0, 0), "mid_reset");
        reset = 1'b0;
        do_write(16'hBC00, 8'h00,   mk(0, 0, 0, 0, 0, 0, 0, 0), 1, "rst_z");
        do_write(16'hBC00, keys[0], mk(0, 0, 0, 0, 0, 0, 0, 0), 1, "rst_nz");
        do_write(16'hBC00, 8'h00,   mk(0, 0, 0, 0, 0, 0, 1, 0), 1, "rst_sync");
        for (int i = 0; i < 14; i++)
            do_write(16'hBC00, keys[i], mk(i + 1, 0, 0, 0, 0, 0, 1, 0), 1,
                     $sformatf("rst_key%0d", i));
        do_write(16'hBC00, 8'hEE, mk(0, 1, 0, 0, 1, 0, 1, 0), 1, "rst_unlock");
        do_write(16'h7F00, 8'hB8, mk(0, 1, 1, 5'h18, 0, 0, 1, 0), 1, "rst_rmr2");

        // plus_mode drop clears everything on the next clock.
        plus_mode = 1'b0;
        @(negedge clk_sys);
        check_out(mk(0, 0, 0, 0, 0, 0, 0, 0), "pm_drop");
        plus_mode = 1'b1;
        @(negedge clk_sys);
        check_out(mk(0, 0, 0, 0, 0, 0, 0, 0), "pm_back");
        do_write(16'hBC00, 8'hFF,   mk(0, 0, 0, 0, 0, 0, 0, 0), 1, "pm_nz");
        do_write(16'hBC00, 8'h00,   mk(0, 0, 0, 0, 0, 0, 1, 0), 1, "pm_z");
        do_write(16'hBC00, keys[0], mk(1, 0, 0, 0, 0, 0, 1, 0), 1, "pm_key0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gx4000_asic_unlock.md
Name: gx4000_asic_unlock

Overview:
Parametrised successor to the Plus ASIC lock gate. Watches CPU writes to the CRTC select port and detects the sync-plus-key unlock sequence; a terminating byte then either unlocks or relocks the ASIC. Once unlocked, it decodes RMR2 writes on the gate-array port to drive ASIC register-page enable and the low-ROM bank select. Sits between the Z80 bus decode and the ASIC RAM/register page mux.

Parameters:
SEQ_LEN, 14, number of key bytes after sync (key table in package; indices 0..SEQ_LEN-1)
PORT_HI, 8'hBC, cpu_addr[15:8] value of CRTC select port
GA_PORT_HI, 8'h7F, cpu_addr[15:8] value of gate-array port; must differ from PORT_HI (elaboration assertion)
UNLOCK_BYTE, 8'hEE, terminating byte that unlocks

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high
plus_mode  in  1  Plus features enabled; low = block held cleared
cpu_addr  in  16  CPU address
cpu_data_in  in  8  CPU write data
cpu_wr  in  1  CPU write strobe, level, may last several clocks
asic_unlocked  out  1  ASIC unlocked flag
asic_page_en  out  1  ASIC registers mapped at 0x4000-0x7FFF
rmr2_q  out  5  last accepted RMR2 bits [4:0]
seq_pos  out  $clog2(SEQ_LEN+1)  key bytes matched so far
unlock_pulse  out  1  one-clock pulse on unlock
lock_pulse  out  1  one-clock pulse on relock
dbg_attempts  out  16  unlock attempts (debug)
dbg_mismatch  out  16  key mismatches (debug)

Behaviour:
- Reset, or plus_mode low (sync clear, same clock): state SYNC_NZ; every output 0.
- Write event: wr_evt = cpu_wr & ~cpu_wr_q. Exactly one event per strobe; cpu_wr_q resets to 0. All decisions take effect on the clock edge after wr_evt is seen, so output latency is 1 clock.
- crtc_hit = wr_evt & cpu_addr[15:8]==PORT_HI.
- ga_hit = wr_evt & cpu_addr[15:8]==GA_PORT_HI.
- FSM advances only on crtc_hit; d = cpu_data_in:
  - SYNC_NZ: d!=0 -> SYNC_Z; else stay.
  - SYNC_Z: d==0 -> KEY, seq_pos=0, dbg_attempts+1; d!=0 -> stay.
  - KEY: d==KEY[seq_pos] -> seq_pos+1; at seq_pos==SEQ_LEN-1 -> FINAL.
  - KEY mismatch: dbg_mismatch+1, seq_pos=0. If d==0 -> SYNC_Z (treat as fresh nonzero/zero pending: stay resynced, next zero required); if d!=0 -> SYNC_Z.
  - FINAL with d==UNLOCK_BYTE: asic_unlocked=1, unlock_pulse if previously 0; then -> SYNC_NZ.
  - FINAL with any other d: asic_unlocked=0, asic_page_en=0, lock_pulse if previously 1; then -> SYNC_NZ.
- Unlock persists across later sync/key activity until a FINAL relock, reset, or plus_mode drop. Partial sequences never change asic_unlocked.
- RMR2: on ga_hit with asic_unlocked=1 and d[7:5]==3'b101: rmr2_q=d[4:0], asic_page_en=(d[4:3]==2'b11). Ignored when locked. Other gate-array writes are ignored.
- Pulses are exactly 1 clock wide. Debug counters saturate at 16'hFFFF.

Optional Feature:
GX4000_UNLOCK_DBG_EN: when defined, dbg_attempts and dbg_mismatch are live saturating counters, cleared on reset or !plus_mode. When undefined, both ports are tied to 0 and the counter logic is absent. Ports exist in both builds.

Decomposition:
- Package gx4000_asic_pkg: KEY table (FF,77,B3,51,A8,D4,62,39,9C,46,2B,15,8A,CD), the UNLOCK_BYTE default, the FSM state enum (SYNC_NZ, SYNC_Z, KEY, FINAL), and the RMR2 tag constant 3'b101.
- Sub-module gx4000_wr_edge: strobe edge detect plus port-hit decode, instanced once and shared by both hits.

Test Plan:
- Writes to 0xBC00 of FF,00,FF,77,B3,51,A8,D4,62,39,9C,46,2B,15,8A,CD,EE -> asic_unlocked=1 one clock after the EE event; unlock_pulse high exactly 1 clock; dbg_attempts=1.
- Same sequence ending in 0x00 instead of EE, after an unlock -> asic_unlocked=0, lock_pulse 1 clock, asic_page_en=0.
- Mismatch at key byte 5 (0x00 in place of A8), then full valid sequence -> dbg_mismatch=1, final unlock succeeds, seq_pos returns to 0.
- Unlocked, write 0x7F00 data 0xB8 -> rmr2_q=5'h18, asic_page_en=1; while locked, same write -> no change.
- cpu_wr held 5 clocks on one 0xBC write -> seq_pos advances by 1 only.
- reset asserted at seq_pos=7, or plus_mode dropped while unlocked -> all outputs 0 next clock; FSM restarts in SYNC_NZ.
